dma_cmd_read_engine: RTL and testbench
======================================

Name: dma_cmd_read_engine

Overview:
Responder side of the TJPU DMA command interface. It accepts a 64-bit {address, byte count} read command with a one-cycle valid strobe. It fetches the data from DDR through a burst read port and streams it out as 256-bit AXI-Stream beats with tkeep/tlast. It raises a one-cycle completion interrupt and is the engine behind the Conv_READ and Concat_READ channels of system_wrapper.

Parameters:
DATA_W, 256, stream and memory data width in bits (32 bytes per beat)
ADDR_W, 32, byte address width
MAX_BURST, 16, maximum beats per memory burst (power of 2, at most 256)
MAX_OUTSTANDING, 2, maximum bursts requested but not yet fully returned

Ports:
clk  in  1  single clock for all logic
rst_n  in  1  asynchronous active-low reset
DMA_CMD  in  64  [63:32] = start byte address, [31:0] = byte count
DMA_Valid  in  1  one-cycle command strobe
busy  out  1  high from command accept until completion
cmd_drop  out  1  sticky; set when DMA_Valid arrives while busy; cleared on the next accepted command
introut  out  1  one-cycle completion pulse
mem_ar_addr  out  ADDR_W  burst start address, 32-byte aligned
mem_ar_len  out  8  burst beats minus 1
mem_ar_valid  out  1  burst request valid
mem_ar_ready  in  1  burst request accepted
mem_r_data  in  DATA_W  read data
mem_r_valid  in  1  read data valid
mem_r_last  in  1  last beat of the current burst
mem_r_ready  out  1  read data accepted
M_tdata  out  DATA_W  stream data
M_tkeep  out  DATA_W/8  byte enables
M_tlast  out  1  final beat of the command
M_tvalid  out  1  stream valid
M_tready  in  1  stream ready

Behaviour:
- Reset (asynchronous, rst_n=0): all outputs 0, counters cleared, FSM to IDLE. A reset mid-transfer abandons the transfer with no introut. The memory side must be reset together with this block.
- Command decode on accept:
  - addr = DMA_CMD[63:37], with the low 5 bits forced to 0.
  - total_beats = DMA_CMD[31:5]; byte count bits [4:0] are ignored.
- Command accept:
  - Accepted only in IDLE when DMA_Valid=1.
  - A strobe while busy is ignored and sets cmd_drop.
  - busy rises the cycle after accept.
- Request FSM states: IDLE, ISSUE, WAIT_DATA, DONE.
  - IDLE -> ISSUE on accept with total_beats > 0.
  - IDLE -> DONE on accept with total_beats = 0; no memory traffic, introut fires 1 cycle after DONE.
  - ISSUE: mem_ar_valid=1 while outstanding < MAX_OUTSTANDING and req_remaining > 0.
  - Burst length = min(MAX_BURST, req_remaining, (4096 - addr[11:0])/32). Bursts never cross a 4 KB boundary.
  - On an ar handshake: addr += len*32, req_remaining -= len, outstanding += 1. mem_ar_addr and mem_ar_len stay stable while valid is high and ready is low.
  - ISSUE -> WAIT_DATA when req_remaining = 0.
  - WAIT_DATA -> DONE when rx_remaining = 0.
  - DONE: introut=1 for one cycle, busy drops the same cycle, then -> IDLE. A new command may be accepted the following cycle.
- Data path (combinational pass-through, zero latency):
  - M_tdata = mem_r_data, M_tvalid = mem_r_valid (only while busy), mem_r_ready = M_tready && busy.
  - M_tkeep is all ones when M_tvalid=1, otherwise 0.
  - Each M handshake decrements rx_remaining.
  - M_tlast = M_tvalid && (rx_remaining == 1).
  - A beat with mem_r_last=1 decrements outstanding.
  - An ar handshake and an r-last on the same cycle leave outstanding unchanged.
- Backpressure: M_tready=0 holds mem_r_ready=0; no beat is dropped or duplicated.
- Address wrap: an address overflow past 2^ADDR_W wraps modulo 2^ADDR_W. No error is flagged.
- Counters: total_beats and remaining counters are 27 bits wide, for a maximum of (2^32-1) bytes.

Test Plan:
- CMD={0x0000_1000, 0x0000_0200} (16 beats), ready always 1 -> one burst: addr 0x1000, len 15. 16 stream beats, tlast on beat 16, introut 1 cycle after DONE, busy low afterwards.
- CMD={0x0000_0FC0, 0x0000_0100} (8 beats) -> bursts split at 4 KB: (0x0FC0, len 1) then (0x1000, len 5). tlast only on beat 8.
- CMD byte count 0x0000_0620 (49 beats), MAX_BURST=16 -> bursts 16,16,16,1. Never more than 2 bursts outstanding with mem_ar_ready always 1 and mem_r_valid delayed 20 cycles.
- M_tready toggling randomly 50% over a 64-beat transfer -> data sequence matches memory exactly; mem_r_ready always equals M_tready.
- DMA_Valid pulsed mid-transfer -> transfer completes unaffected, cmd_drop=1. Next accepted command clears cmd_drop. A byte count of 0 gives introut 2 cycles after accept with no ar request.
- rst_n asserted low at beat 5 of 16 -> all outputs 0 immediately, no introut. A new command after release runs normally.

Source files
------------

// File: rtl/dma_cmd_read_engine.sv
// dma_cmd_read_engine: turns {address, byte count} DMA read commands into
// 4 KB-safe DDR bursts and streams the returned data as AXI-Stream beats.
module dma_cmd_read_engine #(
  parameter int DATA_W          = 256,
  parameter int ADDR_W          = 32,
  parameter int MAX_BURST       = 16,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [63:0]         DMA_CMD,
  input  logic                DMA_Valid,
  output logic                busy,
  output logic                cmd_drop,
  output logic                introut,
  output logic [ADDR_W-1:0]   mem_ar_addr,
  output logic [7:0]          mem_ar_len,
  output logic                mem_ar_valid,
  input  logic                mem_ar_ready,
  input  logic [DATA_W-1:0]   mem_r_data,
  input  logic                mem_r_valid,
  input  logic                mem_r_last,
  output logic                mem_r_ready,
  output logic [DATA_W-1:0]   M_tdata,
  output logic [DATA_W/8-1:0] M_tkeep,
  output logic                M_tlast,
  output logic                M_tvalid,
  input  logic                M_tready
);

  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int CNT_W = 27;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_DATA,
    DONE
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0]  req_rem;
  logic [CNT_W-1:0]  rx_rem;
  logic [OUT_W-1:0]  outstanding;

  logic [CNT_W-1:0]  cmd_beats;
  logic [8:0]        page_beats;
  logic [8:0]        cap_beats;
  logic [8:0]        burst_beats;
  logic              ar_valid;
  logic              ar_fire;
  logic              m_fire;
  logic              r_done;
  logic              unused_bits;

  assign cmd_beats   = DMA_CMD[31:5];
  assign unused_bits = ^{DMA_CMD[36:32], DMA_CMD[4:0]};

  // Beats left before the next 4 KB page boundary.
  assign page_beats = 9'd128 - {2'b00, addr[11:5]};

  always_comb begin
    cap_beats = 9'(MAX_BURST);
    if (req_rem < CNT_W'(cap_beats)) begin
      cap_beats = req_rem[8:0];
    end
    burst_beats = cap_beats;
    if (page_beats < cap_beats) begin
      burst_beats = page_beats;
    end
  end

  // Request side only depends on state registers, so the
  // address and length stay put until the handshake completes.
  assign ar_valid = (state == ISSUE)
                 && (outstanding < OUT_W'(MAX_OUTSTANDING))
                 && (req_rem != '0);
  assign ar_fire  = ar_valid && mem_ar_ready;

  assign mem_ar_valid = ar_valid;
  assign mem_ar_addr  = ar_valid ? addr : '0;
  assign mem_ar_len   = ar_valid ? 8'(burst_beats - 9'd1) : 8'd0;

  assign M_tvalid    = mem_r_valid && busy;
  assign mem_r_ready = M_tready && busy;
  assign M_tdata     = busy ? mem_r_data : '0;
  assign M_tkeep     = {(DATA_W/8){M_tvalid}};
  assign M_tlast     = M_tvalid && (rx_rem == CNT_W'(1));

  assign m_fire = M_tvalid && M_tready;
  assign r_done = m_fire && mem_r_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      addr        <= '0;
      req_rem     <= '0;
      rx_rem      <= '0;
      outstanding <= '0;
      busy        <= 1'b0;
      cmd_drop    <= 1'b0;
      introut     <= 1'b0;
    end else begin
      introut <= 1'b0;

      if (m_fire) begin
        rx_rem <= rx_rem - CNT_W'(1);
      end

      unique case ({ar_fire, r_done})
        2'b10:   outstanding <= outstanding + OUT_W'(1);
        2'b01:   outstanding <= outstanding - OUT_W'(1);
        default: outstanding <= outstanding;
      endcase

      if (DMA_Valid && busy) begin
        cmd_drop <= 1'b1;
      end

      unique case (state)
        IDLE: begin
          if (DMA_Valid) begin
            busy     <= 1'b1;
            cmd_drop <= 1'b0;
            addr     <= ADDR_W'({DMA_CMD[63:37], 5'b00000});
            req_rem  <= cmd_beats;
            rx_rem   <= cmd_beats;
            state    <= (cmd_beats == '0) ? DONE : ISSUE;
          end
        end
        ISSUE: begin
          if (ar_fire) begin
            addr    <= addr + ADDR_W'({burst_beats, 5'b00000});
            req_rem <= req_rem - CNT_W'(burst_beats);
          end
          if (req_rem == '0) begin
            state <= WAIT_DATA;
          end
        end
        WAIT_DATA: begin
          if (rx_rem == '0) begin
            state <= DONE;
          end
        end
        DONE: begin
          introut <= 1'b1;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_cmd_read_engine.sv
// tb_dma_cmd_read_engine: randomized bench with a DDR responder and a
// page-splitting burst model derived from the command rules.
module tb_dma_cmd_read_engine;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [63:0]  DMA_CMD = '0;
  logic         DMA_Valid = 1'b0;
  logic         busy, cmd_drop, introut;
  logic [31:0]  mem_ar_addr;
  logic [7:0]   mem_ar_len;
  logic         mem_ar_valid;
  logic         mem_ar_ready;
  logic [255:0] mem_r_data;
  logic         mem_r_valid, mem_r_last, mem_r_ready;
  logic [255:0] M_tdata;
  logic [31:0]  M_tkeep;
  logic         M_tlast, M_tvalid;
  logic         M_tready;

  int     checks = 0;
  int     failures = 0;
  longint cyc = 0;

  int          r_delay = 0;
  bit          tr_rand = 0;
  bit          ar_rand = 0;
  logic [31:0] salt = 0;

  dma_cmd_read_engine dut (
    .clk(clk), .rst_n(rst_n),
    .DMA_CMD(DMA_CMD), .DMA_Valid(DMA_Valid),
    .busy(busy), .cmd_drop(cmd_drop), .introut(introut),
    .mem_ar_addr(mem_ar_addr), .mem_ar_len(mem_ar_len),
    .mem_ar_valid(mem_ar_valid), .mem_ar_ready(mem_ar_ready),
    .mem_r_data(mem_r_data), .mem_r_valid(mem_r_valid),
    .mem_r_last(mem_r_last), .mem_r_ready(mem_r_ready),
    .M_tdata(M_tdata), .M_tkeep(M_tkeep), .M_tlast(M_tlast),
    .M_tvalid(M_tvalid), .M_tready(M_tready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [255:0] mem_word(input logic [31:0] a);
    logic [255:0] w;
    for (int j = 0; j < 8; j++)
      w[j*32 +: 32] = (a * 32'(j + 1)) ^ salt ^ (32'h1111_1111 * 32'(j));
    return w;
  endfunction

  // DDR responder: in-order bursts, first beat held back r_delay cycles
  typedef struct {
    logic [31:0] addr;
    int          len;
    int          beat;
    longint      t;
  } burst_t;
  burst_t mq[$];

  initial begin
    logic        ar_hs, r_hs;
    logic [31:0] a_s;
    logic [7:0]  l_s;
    mem_ar_ready = 1'b0;
    mem_r_valid  = 1'b0;
    mem_r_last   = 1'b0;
    mem_r_data   = '0;
    M_tready     = 1'b0;
    forever begin
      @(negedge clk);
      ar_hs = mem_ar_valid && mem_ar_ready;
      r_hs  = mem_r_valid && mem_r_ready;
      a_s   = mem_ar_addr;
      l_s   = mem_ar_len;
      @(posedge clk);
      #1;
      if (!rst_n) begin
        mq.delete();
        mem_r_valid = 1'b0;
        mem_r_last  = 1'b0;
        mem_r_data  = '0;
      end else begin
        if (r_hs && mq.size() > 0) begin
          mq[0].beat = mq[0].beat + 1;
          if (mq[0].beat > mq[0].len) void'(mq.pop_front());
        end
        if (ar_hs)
          mq.push_back('{a_s, int'(l_s), 0, cyc + longint'(r_delay)});
        if (mq.size() > 0 && mq[0].t <= cyc) begin
          mem_r_valid = 1'b1;
          mem_r_data  = mem_word(mq[0].addr + 32'(mq[0].beat * 32));
          mem_r_last  = (mq[0].beat == mq[0].len);
        end else begin
          mem_r_valid = 1'b0;
          mem_r_last  = 1'b0;
          mem_r_data  = '0;
        end
      end
      mem_ar_ready = ar_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      M_tready     = tr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Observation logs, filled at the falling edge
  logic [31:0]  ar_a[$];
  int           ar_l[$];
  logic [255:0] rx_d[$];
  logic         rx_t[$];
  logic [31:0]  rx_k[$];
  int     intr_cnt, out_cnt, max_out, ar_bad, rr_bad, keep_bad;
  longint intr_cyc, tl_cyc;

  initial begin
    logic        pv, pr;
    logic [31:0] pa;
    logic [7:0]  pl;
    pv = 0; pr = 0; pa = 0; pl = 0;
    intr_cnt = 0; out_cnt = 0; max_out = 0;
    ar_bad = 0; rr_bad = 0; keep_bad = 0;
    intr_cyc = 0; tl_cyc = 0;
    forever begin
      @(negedge clk);
      if (introut) begin
        intr_cnt++;
        intr_cyc = cyc;
      end
      if (!rst_n) begin
        out_cnt = 0;
        pv = 0;
        pr = 0;
      end else begin
        if (pv && !pr && (!mem_ar_valid || mem_ar_addr !== pa || mem_ar_len !== pl))
          ar_bad++;
        if (mem_ar_valid && mem_ar_ready) begin
          ar_a.push_back(mem_ar_addr);
          ar_l.push_back(int'(mem_ar_len));
          out_cnt++;
        end
        if (mem_r_valid && mem_r_ready && mem_r_last) out_cnt--;
        if (out_cnt > max_out) max_out = out_cnt;
        if (mem_r_ready !== (M_tready && busy)) rr_bad++;
        if (M_tkeep !== {32{M_tvalid}} || (M_tlast && !M_tvalid)) keep_bad++;
        if (M_tvalid && M_tready) begin
          rx_d.push_back(M_tdata);
          rx_t.push_back(M_tlast);
          rx_k.push_back(M_tkeep);
          if (M_tlast) tl_cyc = cyc;
        end
        pv = mem_ar_valid;
        pr = mem_ar_ready;
        pa = mem_ar_addr;
        pl = mem_ar_len;
      end
    end
  end

  // Reference: split the command into bursts by the page/length rules
  logic [31:0] eb_a[$];
  int          eb_l[$];

  function automatic void model(input logic [31:0] a, input logic [31:0] bytes);
    logic [31:0] ad;
    int rem, n;
    ad  = {a[31:5], 5'b00000};
    rem = int'(bytes >> 5);
    eb_a.delete();
    eb_l.delete();
    while (rem > 0) begin
      n = (4096 - int'(ad % 32'd4096)) / 32;
      if (n > 16) n = 16;
      if (n > rem) n = rem;
      eb_a.push_back(ad);
      eb_l.push_back(n - 1);
      ad  = ad + 32'(n * 32);
      rem = rem - n;
    end
  endfunction

  task automatic clear_logs();
    ar_a.delete(); ar_l.delete();
    rx_d.delete(); rx_t.delete(); rx_k.delete();
    intr_cnt = 0; max_out = 0;
    ar_bad = 0; rr_bad = 0; keep_bad = 0;
  endtask

  task automatic start_cmd(input logic [31:0] a, input logic [31:0] bytes);
    clear_logs();
    @(posedge clk);
    #1;
    DMA_CMD   = {a, bytes};
    DMA_Valid = 1'b1;
    @(posedge clk);
    #1;
    DMA_Valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit to);
    to = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (intr_cnt > 0) begin
        to = 1'b0;
        break;
      end
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({busy, cmd_drop, introut} !== 3'b000) begin
      failures++;
      $display("FAIL reset_status: got %b want 000", {busy, cmd_drop, introut});
    end
    checks++;
    if ({mem_ar_valid, mem_ar_addr, mem_ar_len} !== 41'd0) begin
      failures++;
      $display("FAIL reset_ar: got %h want 0", {mem_ar_valid, mem_ar_addr, mem_ar_len});
    end
    checks++;
    if ({mem_r_ready, M_tvalid, M_tlast, M_tkeep} !== 35'd0 || M_tdata !== '0) begin
      failures++;
      $display("FAIL reset_stream: got %h want 0", {mem_r_ready, M_tvalid, M_tlast, M_tkeep});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || intr_cnt != 0) begin
      failures++;
      $display("FAIL reset_idle: busy=%b intr=%0d want 0/0", busy, intr_cnt);
    end
  endtask

  task automatic test_single_burst();
    bit to;
    salt = $urandom; r_delay = 0; tr_rand = 0; ar_rand = 0;
    start_cmd(32'h0000_1000, 32'h0000_0200);
    wait_done(500, to);
    model(32'h0000_1000, 32'h0000_0200);
    checks++;
    if (to) begin failures++; $display("FAIL single_done: introut not seen"); end
    checks++;
    if (ar_a.size() != 1 || (ar_a.size() > 0 && (ar_a[0] !== 32'h1000 || ar_l[0] != 15))) begin
      failures++;
      $display("FAIL single_burst: got %0d bursts want one 0x1000/len15", ar_a.size());
    end
    checks++;
    if (rx_d.size() != 16) begin
      failures++;
      $display("FAIL single_nbeats: got %0d want 16", rx_d.size());
    end
    foreach (rx_d[i]) begin
      checks++;
      if (rx_d[i] !== mem_word(32'h1000 + 32'(i * 32)) || rx_t[i] !== (i == 15) || rx_k[i] !== 32'hFFFF_FFFF) begin
        failures++;
        $display("FAIL single_beat%0d: last=%b keep=%h data=%h", i, rx_t[i], rx_k[i], rx_d[i][31:0]);
      end
    end
    checks++;
    if (intr_cnt != 1 || intr_cyc - tl_cyc != 3) begin
      failures++;
      $display("FAIL single_intr: count=%0d delay=%0d want 1/3", intr_cnt, intr_cyc - tl_cyc);
    end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL single_busy: got %b want 0", busy); end
  endtask

  task automatic test_4k_split();
    bit to;
    salt = $urandom; r_delay = 1; tr_rand = 0; ar_rand = 0;
    start_cmd(32'h0000_0FC0, 32'h0000_0100);
    wait_done(500, to);
    model(32'h0000_0FC0, 32'h0000_0100);
    checks++;
    if (to) begin failures++; $display("FAIL split_done: introut not seen"); end
    checks++;
    if (ar_a.size() != eb_a.size()) begin
      failures++;
      $display("FAIL split_nbursts: got %0d want %0d", ar_a.size(), eb_a.size());
    end
    foreach (eb_a[i]) if (i < ar_a.size()) begin
      checks++;
      if (ar_a[i] !== eb_a[i] || ar_l[i] != eb_l[i]) begin
        failures++;
        $display("FAIL split_burst%0d: got %h/%0d want %h/%0d", i, ar_a[i], ar_l[i], eb_a[i], eb_l[i]);
      end
    end
    checks++;
    if (rx_d.size() != 8) begin failures++; $display("FAIL split_nbeats: got %0d want 8", rx_d.size()); end
    foreach (rx_d[i]) begin
      checks++;
      if (rx_d[i] !== mem_word(32'h0FC0 + 32'(i * 32)) || rx_t[i] !== (i == 7)) begin
        failures++;
        $display("FAIL split_beat%0d: last=%b data=%h", i, rx_t[i], rx_d[i][31:0]);
      end
    end
  endtask

  task automatic test_outstanding();
    bit to;
    salt = $urandom; r_delay = 20; tr_rand = 0; ar_rand = 0;
    start_cmd(32'h0000_8000, 32'h0000_0620);
    wait_done(2000, to);
    model(32'h0000_8000, 32'h0000_0620);
    checks++;
    if (to) begin failures++; $display("FAIL outst_done: introut not seen"); end
    checks++;
    if (ar_a.size() != eb_a.size()) begin
      failures++;
      $display("FAIL outst_nbursts: got %0d want %0d", ar_a.size(), eb_a.size());
    end
    foreach (eb_a[i]) if (i < ar_a.size()) begin
      checks++;
      if (ar_a[i] !== eb_a[i] || ar_l[i] != eb_l[i]) begin
        failures++;
        $display("FAIL outst_burst%0d: got %h/%0d want %h/%0d", i, ar_a[i], ar_l[i], eb_a[i], eb_l[i]);
      end
    end
    checks++;
    if (max_out != 2) begin failures++; $display("FAIL outst_max: got %0d want 2", max_out); end
    checks++;
    if (rx_d.size() != 49 || (rx_d.size() > 0 && rx_t[48] !== 1'b1)) begin
      failures++;
      $display("FAIL outst_nbeats: got %0d want 49 ending in tlast", rx_d.size());
    end
  endtask

  task automatic test_backpressure();
    bit to;
    logic [31:0] a, base;
    salt = $urandom; r_delay = $urandom_range(0, 5); tr_rand = 1; ar_rand = 1;
    a = $urandom;
    base = {a[31:5], 5'b00000};
    start_cmd(a, 32'h0000_0800);
    wait_done(3000, to);
    model(a, 32'h0000_0800);
    checks++;
    if (to) begin failures++; $display("FAIL bp_done: introut not seen"); end
    checks++;
    if (ar_a.size() != eb_a.size()) begin
      failures++;
      $display("FAIL bp_nbursts: got %0d want %0d", ar_a.size(), eb_a.size());
    end
    foreach (eb_a[i]) if (i < ar_a.size()) begin
      checks++;
      if (ar_a[i] !== eb_a[i] || ar_l[i] != eb_l[i]) begin
        failures++;
        $display("FAIL bp_burst%0d: got %h/%0d want %h/%0d", i, ar_a[i], ar_l[i], eb_a[i], eb_l[i]);
      end
    end
    checks++;
    if (rx_d.size() != 64) begin failures++; $display("FAIL bp_nbeats: got %0d want 64", rx_d.size()); end
    foreach (rx_d[i]) begin
      checks++;
      if (rx_d[i] !== mem_word(base + 32'(i * 32)) || rx_t[i] !== (i == 63)) begin
        failures++;
        $display("FAIL bp_beat%0d: last=%b data=%h", i, rx_t[i], rx_d[i][31:0]);
      end
    end
    checks++;
    if (rr_bad != 0 || keep_bad != 0 || ar_bad != 0 || max_out > 2) begin
      failures++;
      $display("FAIL bp_rules: rready=%0d keep=%0d ar=%0d maxout=%0d want 0/0/0/<=2", rr_bad, keep_bad, ar_bad, max_out);
    end
  endtask

  task automatic test_cmd_drop();
    bit to;
    salt = $urandom; r_delay = 2; tr_rand = 1; ar_rand = 0;
    start_cmd(32'h0000_5000, 32'h0000_0400);
    repeat (8) @(posedge clk);
    #1;
    DMA_CMD   = {32'h0000_9000, 32'h0000_0040};
    DMA_Valid = 1'b1;
    @(posedge clk);
    #1;
    DMA_Valid = 1'b0;
    @(negedge clk);
    checks++;
    if (cmd_drop !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL drop_set: cmd_drop=%b busy=%b want 1/1", cmd_drop, busy);
    end
    wait_done(3000, to);
    model(32'h0000_5000, 32'h0000_0400);
    checks++;
    if (to) begin failures++; $display("FAIL drop_done: introut not seen"); end
    checks++;
    if (ar_a.size() != eb_a.size() || rx_d.size() != 32 || intr_cnt != 1) begin
      failures++;
      $display("FAIL drop_xfer: bursts=%0d beats=%0d intr=%0d want %0d/32/1", ar_a.size(), rx_d.size(), intr_cnt, eb_a.size());
    end
    foreach (rx_d[i]) begin
      checks++;
      if (rx_d[i] !== mem_word(32'h5000 + 32'(i * 32)) || rx_t[i] !== (i == 31)) begin
        failures++;
        $display("FAIL drop_beat%0d: last=%b data=%h", i, rx_t[i], rx_d[i][31:0]);
      end
    end
    checks++;
    if (cmd_drop !== 1'b1) begin failures++; $display("FAIL drop_sticky: got %b want 1", cmd_drop); end
    tr_rand = 0;
    start_cmd(32'h0000_7000, 32'h0000_001F);
    @(negedge clk);
    checks++;
    if ({busy, cmd_drop, introut} !== 3'b100) begin
      failures++;
      $display("FAIL zero_accept: busy/drop/intr=%b want 100", {busy, cmd_drop, introut});
    end
    @(negedge clk);
    checks++;
    if ({busy, introut} !== 2'b01) begin
      failures++;
      $display("FAIL zero_intr: busy/intr=%b want 01", {busy, introut});
    end
    @(negedge clk);
    checks++;
    if (introut !== 1'b0 || ar_a.size() != 0 || intr_cnt != 1) begin
      failures++;
      $display("FAIL zero_after: intr=%b ars=%0d pulses=%0d want 0/0/1", introut, ar_a.size(), intr_cnt);
    end
  endtask

  task automatic test_reset_mid();
    bit to;
    bit seen;
    salt = $urandom; r_delay = 0; tr_rand = 0; ar_rand = 0;
    start_cmd(32'h0000_3000, 32'h0000_0200);
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rx_d.size() >= 4) begin
        seen = 1;
        break;
      end
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL rmid_reach: got %0d beats want 4", rx_d.size()); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, cmd_drop, introut, mem_ar_valid, mem_r_ready, M_tvalid, M_tlast} !== 7'd0) begin
      failures++;
      $display("FAIL rmid_ctrl: got %b want 0", {busy, cmd_drop, introut, mem_ar_valid, mem_r_ready, M_tvalid, M_tlast});
    end
    checks++;
    if (M_tkeep !== '0 || M_tdata !== '0 || mem_ar_addr !== '0 || mem_ar_len !== '0) begin
      failures++;
      $display("FAIL rmid_data: keep=%h data=%h want 0", M_tkeep, M_tdata[31:0]);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (intr_cnt != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rmid_nointr: intr=%0d busy=%b want 0/0", intr_cnt, busy);
    end
    salt = $urandom;
    start_cmd(32'h0000_3000, 32'h0000_0200);
    wait_done(500, to);
    checks++;
    if (to || intr_cnt != 1 || rx_d.size() != 16 || ar_a.size() != 1) begin
      failures++;
      $display("FAIL rmid_rerun: to=%b intr=%0d beats=%0d bursts=%0d want 0/1/16/1", to, intr_cnt, rx_d.size(), ar_a.size());
    end
    foreach (rx_d[i]) begin
      checks++;
      if (rx_d[i] !== mem_word(32'h3000 + 32'(i * 32)) || rx_t[i] !== (i == 15)) begin
        failures++;
        $display("FAIL rmid_beat%0d: last=%b data=%h", i, rx_t[i], rx_d[i][31:0]);
      end
    end
  endtask

  task automatic test_random();
    bit to;
    logic [31:0] a, b, base;
    int nb;
    for (int k = 0; k < 7; k++) begin
      salt = $urandom;
      r_delay = $urandom_range(0, 8);
      tr_rand = 1'($urandom_range(0, 1));
      ar_rand = 1'($urandom_range(0, 1));
      if (k == 0) begin
        a = 32'hFFFF_FFC0;
        b = 32'h0000_0080;
      end else begin
        a = (k % 3 == 0) ? (32'hFFFF_F000 | ($urandom & 32'hFFF)) : $urandom;
        b = 32'($urandom_range(0, 80) * 32 + $urandom_range(0, 31));
      end
      base = {a[31:5], 5'b00000};
      nb = int'(b >> 5);
      start_cmd(a, b);
      wait_done(3000, to);
      model(a, b);
      checks++;
      if (to || intr_cnt != 1) begin
        failures++;
        $display("FAIL rand%0d_done: to=%b intr=%0d want 0/1", k, to, intr_cnt);
      end
      checks++;
      if (ar_a.size() != eb_a.size() || rx_d.size() != nb) begin
        failures++;
        $display("FAIL rand%0d_counts: bursts=%0d beats=%0d want %0d/%0d", k, ar_a.size(), rx_d.size(), eb_a.size(), nb);
      end
      foreach (eb_a[i]) if (i < ar_a.size()) begin
        checks++;
        if (ar_a[i] !== eb_a[i] || ar_l[i] != eb_l[i]) begin
          failures++;
          $display("FAIL rand%0d_burst%0d: got %h/%0d want %h/%0d", k, i, ar_a[i], ar_l[i], eb_a[i], eb_l[i]);
        end
      end
      foreach (rx_d[i]) begin
        checks++;
        if (rx_d[i] !== mem_word(base + 32'(i * 32)) || rx_t[i] !== (i == nb - 1)) begin
          failures++;
          $display("FAIL rand%0d_beat%0d: last=%b data=%h", k, i, rx_t[i], rx_d[i][31:0]);
        end
      end
      checks++;
      if (rr_bad != 0 || keep_bad != 0 || ar_bad != 0 || max_out > 2) begin
        failures++;
        $display("FAIL rand%0d_rules: rready=%0d keep=%0d ar=%0d maxout=%0d", k, rr_bad, keep_bad, ar_bad, max_out);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_4k_split();
    test_outstanding();
    test_backpressure();
    test_cmd_drop();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
